// File: rtl/iob_vexriscv_bus_merge.sv
// Two-to-one request merger between the VexRiscv wrapper and a single memory port.
// Instruction and data requests are arbitrated round-robin onto mem_req, and read
// responses are routed back in order using a small owner FIFO. This lets a
// pipelined memory return rvalid one or more cycles after it accepts a read.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-low reset
//   ibus_req   {valid, addr, wdata, wstrb} from the instruction master
//   ibus_resp  {rdata, rvalid, ready} to the instruction master
//   dbus_req   {valid, addr, wdata, wstrb} from the data master
//   dbus_resp  {rdata, rvalid, ready} to the data master
//   mem_req    merged request to memory, same packing as the master requests
//   mem_resp   {rdata, rvalid, ready} from memory
//   err        sticky; set when rvalid arrives with no read outstanding
module iob_vexriscv_bus_merge #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 2,
    localparam int unsigned STRB_W   = DATA_W / 8,
    localparam int unsigned REQ_W    = 1 + ADDR_W + DATA_W + STRB_W,
    localparam int unsigned RESP_W   = DATA_W + 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REQ_W-1:0]  ibus_req,
    output logic [RESP_W-1:0] ibus_resp,
    input  logic [REQ_W-1:0]  dbus_req,
    output logic [RESP_W-1:0] dbus_resp,
    output logic [REQ_W-1:0]  mem_req,
    input  logic [RESP_W-1:0] mem_resp,
    output logic              err
);

    localparam int unsigned PtrW = $clog2(MAX_OUTST);
    localparam int unsigned CntW = PtrW + 1;

    // Request unpacking
    logic             i_valid;
    logic             d_valid;
    logic [REQ_W-2:0] i_fields;
    logic [REQ_W-2:0] d_fields;

    assign i_valid  = ibus_req[REQ_W-1];
    assign d_valid  = dbus_req[REQ_W-1];
    assign i_fields = ibus_req[REQ_W-2:0];
    assign d_fields = dbus_req[REQ_W-2:0];

    // Response unpacking
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              mem_ready;

    assign mem_rdata  = mem_resp[RESP_W-1:2];
    assign mem_rvalid = mem_resp[1];
    assign mem_ready  = mem_resp[0];

    // State
    logic                 last_q, last_d;
    logic [MAX_OUTST-1:0] own_q, own_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 err_q, err_d;

    // Arbitration and flow control
    logic             sel_valid;
    logic             sel_data;
    logic [REQ_W-2:0] sel_fields;
    logic             is_read;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_pop;
    logic             fifo_push;
    logic             block;
    logic             grant;
    logic             accept;
    logic             head_data;

    always_comb begin
        sel_valid = i_valid | d_valid;
        // last_q == 1 means data won the last accepted transfer, so a tie goes to
        // instruction; a single valid master always wins.
        if (i_valid && d_valid) begin
            sel_data = ~last_q;
        end else begin
            sel_data = d_valid;
        end
        sel_fields = sel_data ? d_fields : i_fields;
        is_read    = (sel_fields[STRB_W-1:0] == '0);
    end

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CntW'(MAX_OUTST));
    assign fifo_pop   = rst & mem_rvalid & ~fifo_empty;
    // A pop in the same cycle frees a slot, so a full FIFO only stalls reads that
    // have no matching response retiring alongside them. Writes never stall.
    assign block      = fifo_full & ~fifo_pop & is_read;
    assign grant      = rst & sel_valid & ~block;
    assign accept     = grant & mem_ready;
    assign fifo_push  = accept & is_read;
    assign head_data  = own_q[rd_ptr_q];

    // Outputs
    always_comb begin
        mem_req   = sel_valid ? {grant, sel_fields} : '0;
        ibus_resp = {mem_rdata, fifo_pop & ~head_data, grant & mem_ready & ~sel_data};
        dbus_resp = {mem_rdata, fifo_pop & head_data, grant & mem_ready & sel_data};
        err       = err_q;
    end

    // Next state
    always_comb begin
        last_d   = accept ? sel_data : last_q;
        own_d    = own_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (fifo_push) begin
            own_d[wr_ptr_q] = sel_data;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({fifo_push, fifo_pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
        err_d = err_q | (mem_rvalid & fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_q   <= 1'b1;
            own_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            last_q   <= last_d;
            own_q    <= own_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

endmodule
